// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage load/store unit: FSM state
// encoding, cache-bus tag field values and the tag header builder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsuState_t;

  // Tag header fields, most significant first: {dir, space, kind}.
  localparam logic READ   = 1'b1;
  localparam logic WRITE  = 1'b0;
  localparam logic MEMORY = 1'b0;
  localparam logic DATA   = 1'b0;

  localparam int TAG_HDR_W = 3;

  // Header placed in the top bits of every request tag; the rest is zero pad.
  function automatic logic [TAG_HDR_W-1:0] make_tag(input logic dir);
    return {dir, MEMORY, DATA};
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Bus watchdog for the load/store unit. Counts enabled cycles and flags
// expiry in the TMO_CYC-th consecutive enabled cycle, so the owner can
// leave its wait state exactly TMO_CYC edges after entering it.
// TMO_CYC = 0 disables the watchdog entirely.
module mem_watchdog #(
  parameter int unsigned TMO_CYC = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TMO_CYC == 0) begin : g_off
    logic unusedWd;
    assign unusedWd = ^{clk, reset, clear, enable};
    assign expired  = 1'b0;
  end else begin : g_on
    localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TMO_CYC - 1);

    logic [CNT_W-1:0] count;
    logic             hit;

    assign hit     = (count == LAST);
    assign expired = enable & hit;

    // Count cycles spent waiting on the bus; saturate at the expiry value.
    always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state is updated with non-blocking assignments so every
      // flop samples pre-edge values regardless of block ordering.
      if (reset) begin
        count <= '0;
      end else if (clear) begin
        count <= '0;
      end else if (enable && !hit) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage load/store unit: launches one data-cache request per
// instruction, holds the pipeline until the cache answers with the matching
// tag (or the watchdog fires) and then presents the result until advance_in.
// Optional feature: define MEM_LSU_STORE_EN to issue WRITE requests for
// instructions whose destination is memory.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TAG_W   = 13,
  parameter int unsigned TMO_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              can_mem_in,
  input  logic              rd_src1_in,
  input  logic              rd_src2_in,
  input  logic              wr_dest_in,
  input  logic [ADDR_W-1:0] addr_src1_in,
  input  logic [ADDR_W-1:0] addr_src2_in,
  input  logic [ADDR_W-1:0] addr_dest_in,
  input  logic [DATA_W-1:0] st_data_in,
  input  logic              advance_in,
  output logic              reqcyc,
  output logic [ADDR_W-1:0] req,
  output logic [DATA_W-1:0] req_wdata,
  output logic [TAG_W-1:0]  reqtag,
  input  logic              reqack,
  input  logic              respcyc,
  input  logic [DATA_W-1:0] resp,
  input  logic [TAG_W-1:0]  resptag,
  output logic              respack,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              stall_out,
  output logic              success_out,
  output logic              fault_out
);

  lsuState_t         state;
  logic              reqCycR;
  logic [ADDR_W-1:0] reqAddrR;
  logic [TAG_W-1:0]  reqTagR;
  logic              respAckR;
  logic [DATA_W-1:0] memDataR;
  logic              faultR;

  logic [ADDR_W-1:0] selAddr;
  logic              selDir;
  logic [TAG_W-1:0]  selTag;
  logic              isStore;
  logic              memOp;
  logic              bothSrc;
  logic              accept;
  logic              launch;
  logic              inFlight;
  logic              respMatch;
  logic              wdExpired;

`ifdef MEM_LSU_STORE_EN
  logic [DATA_W-1:0] reqWdataR;
  assign isStore   = wr_dest_in;
  assign req_wdata = reqWdataR;
`else
  logic unusedStore;
  assign isStore     = 1'b0;
  assign req_wdata   = '0;
  assign unusedStore = ^{wr_dest_in, addr_dest_in, st_data_in};
`endif

  assign bothSrc   = rd_src1_in & rd_src2_in;
  assign memOp     = rd_src1_in | rd_src2_in | isStore;
  // Reset is folded in so the combinational outputs read 0 while it is held.
  assign accept    = (state == IDLE) & valid_in & can_mem_in & ~reset;
  assign launch    = accept & memOp & ~bothSrc;
  assign inFlight  = (state == REQ) | (state == WAIT);
  assign respMatch = respcyc & (resptag == reqTagR);

  // Pick the bus address and direction: src1 over src2 over the store address.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    selAddr = addr_src1_in;
    selDir  = READ;
    if (!rd_src1_in) begin
      if (rd_src2_in) begin
        selAddr = addr_src2_in;
      end
`ifdef MEM_LSU_STORE_EN
      else begin
        selAddr = addr_dest_in;
        selDir  = WRITE;
      end
`endif
    end
  end

  // Request tag: header fields in the top bits, zero pad below.
  always_comb begin
    selTag = '0;
    selTag[TAG_W-1 -: TAG_HDR_W] = make_tag(selDir);
  end

  mem_watchdog #(
    .TMO_CYC(TMO_CYC)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (~inFlight),
    .enable (inFlight),
    .expired(wdExpired)
  );

  // Access FSM with registered bus and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      reqCycR  <= 1'b0;
      reqAddrR <= '0;
      reqTagR  <= '0;
      respAckR <= 1'b0;
      memDataR <= '0;
      faultR   <= 1'b0;
`ifdef MEM_LSU_STORE_EN
      reqWdataR <= '0;
`endif
    end else begin
      respAckR <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!memOp) begin
              memDataR <= '0;
              state    <= DONE;
            end else if (bothSrc) begin
              faultR <= 1'b1;
              state  <= DONE;
            end else begin
              reqCycR  <= 1'b1;
              reqAddrR <= selAddr;
              reqTagR  <= selTag;
`ifdef MEM_LSU_STORE_EN
              reqWdataR <= (selDir == WRITE) ? st_data_in : '0;
`endif
              state    <= REQ;
            end
          end
        end
        REQ: begin
          if (reqack && respMatch) begin
            reqCycR  <= 1'b0;
            respAckR <= 1'b1;
            if (reqTagR[TAG_W-1] == READ) memDataR <= resp;
            state    <= DONE;
          end else if (wdExpired) begin
            reqCycR <= 1'b0;
            faultR  <= 1'b1;
            state   <= DONE;
          end else if (reqack) begin
            reqCycR <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (respMatch) begin
            respAckR <= 1'b1;
            if (reqTagR[TAG_W-1] == READ) memDataR <= resp;
            state    <= DONE;
          end else if (wdExpired) begin
            faultR <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (advance_in) begin
            faultR <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign reqcyc       = reqCycR;
  assign req          = reqAddrR;
  assign reqtag       = reqTagR;
  assign respack      = respAckR;
  assign mem_data_out = memDataR;
  assign fault_out    = faultR;
  assign stall_out    = launch | inFlight;
  assign success_out  = (state == DONE) | (accept & ~memOp);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: the bench plays the data cache, schedules
// reqack/respcyc per transaction and predicts every cycle's outputs from
// the transaction description (kind, ack cycle, response cycles, timeout).
module tb_mem_stage_lsu;
  import mem_pkg::*;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 13;
  localparam int TMO    = 8;
  localparam int NEVER  = 1000;
`ifdef MEM_LSU_STORE_EN
  localparam bit STORE_EN = 1'b1;
`else
  localparam bit STORE_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              valid_in, can_mem_in, rd_src1_in, rd_src2_in, wr_dest_in;
  logic [ADDR_W-1:0] addr_src1_in, addr_src2_in, addr_dest_in;
  logic [DATA_W-1:0] st_data_in;
  logic              advance_in;
  logic              reqcyc;
  logic [ADDR_W-1:0] req;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  reqtag;
  logic              reqack, respcyc;
  logic [DATA_W-1:0] resp;
  logic [TAG_W-1:0]  resptag;
  logic              respack;
  logic [DATA_W-1:0] mem_data_out;
  logic              stall_out, success_out, fault_out;

  int nChecks = 0;
  int nErrors = 0;
  logic [DATA_W-1:0] modelData;

  typedef enum int {K_NOOP, K_BOTH, K_SRC1, K_SRC2, K_DEST, K_SRC1_DEST, K_SRC2_DEST} kind_t;

  mem_stage_lsu #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .TMO_CYC(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .can_mem_in  (can_mem_in),
    .rd_src1_in  (rd_src1_in),
    .rd_src2_in  (rd_src2_in),
    .wr_dest_in  (wr_dest_in),
    .addr_src1_in(addr_src1_in),
    .addr_src2_in(addr_src2_in),
    .addr_dest_in(addr_dest_in),
    .st_data_in  (st_data_in),
    .advance_in  (advance_in),
    .reqcyc      (reqcyc),
    .req         (req),
    .req_wdata   (req_wdata),
    .reqtag      (reqtag),
    .reqack      (reqack),
    .respcyc     (respcyc),
    .resp        (resp),
    .resptag     (resptag),
    .respack     (respack),
    .mem_data_out(mem_data_out),
    .stall_out   (stall_out),
    .success_out (success_out),
    .fault_out   (fault_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // {dir, MEMORY, DATA} in the top three bits, zero below.
  function automatic logic [TAG_W-1:0] tagFor(input logic dir);
    logic [TAG_W-1:0] t;
    t = '0;
    t[TAG_W-1] = dir;
    t[TAG_W-2] = MEMORY;
    t[TAG_W-3] = DATA;
    return t;
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleBus();
    reqack  = 1'b0;
    respcyc = 1'b0;
    resp    = '0;
    resptag = '0;
  endtask

  task automatic scrambleInputs();
    can_mem_in   = 1'($urandom);
    rd_src1_in   = 1'($urandom);
    rd_src2_in   = 1'($urandom);
    wr_dest_in   = 1'($urandom);
    addr_src1_in = rnd64();
    addr_src2_in = rnd64();
    addr_dest_in = rnd64();
    st_data_in   = rnd64();
  endtask

  // One instruction from IDLE through advance back to IDLE. Cycle numbers
  // (ackCyc/badCyc/goodCyc) count from the first cycle after the launch
  // cycle; -1 means no such event, NEVER means no reqack at all.
  task automatic doTxn(input kind_t kind, input logic [63:0] a1, input logic [63:0] a2,
                       input logic [63:0] ad, input logic [63:0] sd, input logic [63:0] rdata,
                       input int ackCyc, input int badCyc, input int goodCyc);
    logic s1, s2, wd, both, isWrite, memReq, noop, timeout, done, expFault;
    logic [63:0] expAddr, expWdata;
    logic [TAG_W-1:0] expTag;
    int hold;
    s1 = (kind == K_SRC1) || (kind == K_BOTH) || (kind == K_SRC1_DEST);
    s2 = (kind == K_SRC2) || (kind == K_BOTH) || (kind == K_SRC2_DEST);
    wd = (kind == K_DEST) || (kind == K_SRC1_DEST) || (kind == K_SRC2_DEST);
    both     = (kind == K_BOTH);
    isWrite  = (kind == K_DEST) && STORE_EN;
    memReq   = !both && (s1 || s2 || isWrite);
    noop     = !both && !memReq;
    expAddr  = s1 ? a1 : (s2 ? a2 : ad);
    expWdata = isWrite ? sd : 64'h0;
    expTag   = tagFor(isWrite ? WRITE : READ);
    timeout  = (goodCyc < 0);
    expFault = both;

    valid_in = 1'b1; can_mem_in = 1'b1; advance_in = 1'b0;
    rd_src1_in = s1; rd_src2_in = s2; wr_dest_in = wd;
    addr_src1_in = a1; addr_src2_in = a2; addr_dest_in = ad; st_data_in = sd;
    idleBus();
    @(negedge clk);
    check("launch_stall", stall_out, memReq);
    check("launch_success", success_out, noop);
    check("launch_reqcyc", reqcyc, 1'b0);
    nextCycle();
    valid_in = 1'b0;
    scrambleInputs();

    if (!memReq) begin
      if (noop) modelData = '0;
      @(negedge clk);
      check("direct_success", success_out, 1'b1);
      check("direct_fault", fault_out, expFault);
      check("direct_stall", stall_out, 1'b0);
      check("direct_reqcyc", reqcyc, 1'b0);
      check("direct_respack", respack, 1'b0);
      check("direct_data", mem_data_out, modelData);
      nextCycle();
    end else begin
      done = 1'b0;
      for (int cyc = 0; cyc < 3 * TMO && !done; cyc++) begin
        reqack  = (cyc == ackCyc);
        respcyc = (cyc == badCyc) || (cyc == goodCyc);
        resp    = (cyc == goodCyc) ? rdata : rnd64();
        resptag = (cyc == goodCyc) ? expTag : (expTag ^ TAG_W'($urandom_range(1, 8191)));
        @(negedge clk);
        if ((timeout && cyc == TMO) || (!timeout && cyc == goodCyc + 1)) begin
          done = 1'b1;
          if (timeout) expFault = 1'b1;
          else if (!isWrite) modelData = rdata;
          check("done_success", success_out, 1'b1);
          check("done_stall", stall_out, 1'b0);
          check("done_fault", fault_out, expFault);
          check("done_reqcyc", reqcyc, 1'b0);
          check("done_respack", respack, !timeout);
          check("done_data", mem_data_out, modelData);
        end else begin
          check("busy_stall", stall_out, 1'b1);
          check("busy_success", success_out, 1'b0);
          check("busy_respack", respack, 1'b0);
          check("busy_reqcyc", reqcyc, cyc <= ackCyc);
          if (cyc <= ackCyc) begin
            check("busy_addr", req, expAddr);
            check("busy_tag", reqtag, expTag);
            check("busy_wdata", req_wdata, expWdata);
          end
        end
        nextCycle();
        idleBus();
      end
      if (!done) check("txn_completed", 1'b0, 1'b1);
    end

    hold = $urandom_range(0, 2);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_success", success_out, 1'b1);
      check("hold_fault", fault_out, expFault);
      check("hold_stall", stall_out, 1'b0);
      check("hold_respack", respack, 1'b0);
      check("hold_data", mem_data_out, modelData);
      nextCycle();
    end
    advance_in = 1'b1;
    @(negedge clk);
    check("adv_success", success_out, 1'b1);
    check("adv_fault", fault_out, expFault);
    nextCycle();
    advance_in = 1'b0;
    @(negedge clk);
    check("idle_success", success_out, 1'b0);
    check("idle_fault", fault_out, 1'b0);
    check("idle_stall", stall_out, 1'b0);
    check("idle_reqcyc", reqcyc, 1'b0);
    nextCycle();
  endtask

  // Reset arrives while waiting for the response; a late response is ignored.
  task automatic resetInWait();
    valid_in = 1'b1; can_mem_in = 1'b1; advance_in = 1'b0;
    rd_src1_in = 1'b1; rd_src2_in = 1'b0; wr_dest_in = 1'b0;
    addr_src1_in = 64'h3000;
    idleBus();
    nextCycle();
    valid_in = 1'b0; rd_src1_in = 1'b0;
    reqack = 1'b1;
    nextCycle();
    reqack = 1'b0;
    nextCycle();
    @(negedge clk);
    check("rst_pre_stall", stall_out, 1'b1);
    #2 reset = 1'b1;
    #1;
    modelData = '0;
    check("rst_reqcyc", reqcyc, 1'b0);
    check("rst_stall", stall_out, 1'b0);
    check("rst_success", success_out, 1'b0);
    check("rst_fault", fault_out, 1'b0);
    check("rst_respack", respack, 1'b0);
    check("rst_req", req, 64'h0);
    check("rst_tag", reqtag, 13'h0);
    check("rst_data", mem_data_out, modelData);
    @(negedge clk);
    reset = 1'b0;
    nextCycle();
    respcyc = 1'b1; resptag = tagFor(READ); resp = rnd64();
    @(negedge clk);
    check("late_stall", stall_out, 1'b0);
    check("late_success", success_out, 1'b0);
    nextCycle();
    idleBus();
    @(negedge clk);
    check("late_respack", respack, 1'b0);
    check("late_success2", success_out, 1'b0);
    check("late_data", mem_data_out, modelData);
    nextCycle();
  endtask

  initial begin
    kind_t kind;
    int ack, bad, good;
    reset = 1'b0;
    valid_in = 1'b0; can_mem_in = 1'b0; advance_in = 1'b0;
    rd_src1_in = 1'b0; rd_src2_in = 1'b0; wr_dest_in = 1'b0;
    addr_src1_in = '0; addr_src2_in = '0; addr_dest_in = '0; st_data_in = '0;
    idleBus();
    modelData = '0;
    #1 reset = 1'b1;
    #6;
    check("reset_reqcyc", reqcyc, 1'b0);
    check("reset_stall", stall_out, 1'b0);
    check("reset_success", success_out, 1'b0);
    check("reset_fault", fault_out, 1'b0);
    check("reset_respack", respack, 1'b0);
    check("reset_data", mem_data_out, 64'h0);
    check("reset_wdata", req_wdata, 64'h0);
    check("reset_tag", reqtag, 13'h0);
    @(negedge clk);
    reset = 1'b0;
    nextCycle();

    doTxn(K_SRC1, 64'h1000, rnd64(), rnd64(), rnd64(), 64'hDEADBEEF, 0, -1, 3);
    doTxn(K_NOOP, rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), 0, -1, 0);
    doTxn(K_BOTH, rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), 0, -1, 0);
    doTxn(K_SRC2, rnd64(), 64'h4440, rnd64(), rnd64(), 64'h1234_5678_9ABC_DEF0, 0, 1, 3);
    doTxn(K_SRC1, 64'h5000, rnd64(), rnd64(), rnd64(), rnd64(), 0, -1, -1);
    doTxn(K_SRC2, rnd64(), 64'h6000, rnd64(), rnd64(), rnd64(), NEVER, -1, -1);
    doTxn(K_SRC1_DEST, 64'h7000, rnd64(), 64'h7100, rnd64(), 64'hCAFE_F00D, 1, -1, 1);
    doTxn(K_DEST, rnd64(), rnd64(), 64'h2000, 64'h55, rnd64(), 0, -1, 2);
    resetInWait();

    for (int t = 0; t < 40; t++) begin
      kind = kind_t'($urandom_range(0, 6));
      ack  = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) begin
        good = -1;
        bad  = -1;
        if ($urandom_range(0, 1) == 1) ack = NEVER;
      end else begin
        good = ack + int'($urandom_range(0, 4));
        if (good > ack && $urandom_range(0, 1) == 1) bad = int'($urandom_range(ack, good - 1));
        else bad = -1;
      end
      doTxn(kind, rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), ack, bad, good);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
